// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//
// Purpose:
//    Shared types and helpers for the single-clock FIFO. The FIFO sorts the
//    push/pop requests seen on each edge into one of four operations. The
//    pointer, count and data-out update logic is written in terms of that
//    operation instead of a tangle of accept bits.
//
// Contents:
//    fifo_op_e     - operation performed on a clock edge
//    fifoOpDecode  - maps the accepted-read / accepted-write pair to an op
// ---------------------------------------------------------------------------
package fifo_pkg;

   // Operation carried out on a rising edge, after the accept rules have
   // been applied (a rejected request never shows up here).
   typedef enum logic [1:0] {
      OP_IDLE  = 2'b00,
      OP_WRITE = 2'b01,
      OP_READ  = 2'b10,
      OP_BOTH  = 2'b11
   } fifo_op_e;

   // Turn the two accept decisions into a single operation code.
   function automatic fifo_op_e fifoOpDecode(input logic readAccept,
                                             input logic writeAccept);
      fifo_op_e op;
      op = OP_IDLE;
      case ({readAccept, writeAccept})
         2'b01:   op = OP_WRITE;
         2'b10:   op = OP_READ;
         2'b11:   op = OP_BOTH;
         default: op = OP_IDLE;
      endcase
      return op;
   endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
//
// Purpose:
//    Simple dual-port register array used as FIFO storage. It has one
//    synchronous write port and one asynchronous (combinational) read port.
//    The storage is deliberately not reset, because the FIFO control logic
//    never exposes a word that was not written since the last reset.
//
// Ports:
//    clk       in   system clock, writes occur on the rising edge
//    wrEn_i    in   write enable
//    wrAddr_i  in   write address
//    wrData_i  in   write data
//    rdAddr_i  in   read address
//    rdData_o  out  contents of the word at rdAddr_i
// ---------------------------------------------------------------------------
module fifo_mem #(
   parameter int DATA_SIZE    = 8,
   parameter int ADDRESS_SIZE = 3
) (
   input  logic                    clk,
   input  logic                    wrEn_i,
   input  logic [ADDRESS_SIZE-1:0] wrAddr_i,
   input  logic [DATA_SIZE-1:0]    wrData_i,
   input  logic [ADDRESS_SIZE-1:0] rdAddr_i,
   output logic [DATA_SIZE-1:0]    rdData_o
);

   localparam int DEPTH = 2 ** ADDRESS_SIZE;

   logic [DATA_SIZE-1:0] mem_q [DEPTH];

   // Write port: capture the data on the clock edge when enabled. The array
   // is not reset.
   always_ff @(posedge clk) begin
      if (wrEn_i) begin
         mem_q[wrAddr_i] <= wrData_i;
      end
   end

   // Read port: purely combinational. The FIFO registers the value into its
   // own output register, so a read and a write to the same slot on the
   // same edge hands out the old word.
   assign rdData_o = mem_q[rdAddr_i];

endmodule : fifo_mem

// File: rtl/fifo.sv
// ---------------------------------------------------------------------------
// fifo
//
// Purpose:
//    Single-clock synchronous FIFO with DEPTH = 2**ADDRESS_SIZE entries of
//    DATA_SIZE bits. It has registered read data and combinational full and
//    empty flags derived from an occupancy count. It also has sticky
//    overflow and underflow error flags that clear only on reset.
//
// Ports:
//    clk        in   system clock, all state changes on the rising edge
//    rst        in   asynchronous active-low reset
//    push       in   write request
//    pop        in   read request
//    data_in    in   write data
//    data_out   out  registered read data, valid the cycle after a pop
//    full       out  FIFO holds DEPTH entries
//    empty      out  FIFO holds no entries
//    overflow   out  sticky: push seen while full without a pop
//    underflow  out  sticky: pop seen while empty without a push
// ---------------------------------------------------------------------------
module fifo
   import fifo_pkg::*;
#(
   parameter int DATA_SIZE    = 8,
   parameter int ADDRESS_SIZE = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DATA_SIZE-1:0] data_in,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 full,
   output logic                 empty,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int DEPTH = 2 ** ADDRESS_SIZE;
   localparam logic [ADDRESS_SIZE:0] DEPTH_CNT = (ADDRESS_SIZE + 1)'(DEPTH);

   logic [ADDRESS_SIZE-1:0] wrPtr_q, wrPtr_d;
   logic [ADDRESS_SIZE-1:0] rdPtr_q, rdPtr_d;
   logic [ADDRESS_SIZE:0]   count_q, count_d;
   logic [DATA_SIZE-1:0]    dataOut_q, dataOut_d;
   logic                    overflow_q, overflow_d;
   logic                    underflow_q, underflow_d;

   logic                    writeAccept;
   logic                    readAccept;
   logic                    overflowEvent;
   logic                    underflowEvent;
   logic [DATA_SIZE-1:0]    memRdData;
   fifo_op_e                op;

   // Status flags come straight from the registered count, so they move on
   // the same edge as the count itself.
   assign full  = (count_q == DEPTH_CNT);
   assign empty = (count_q == '0);

   // Accept rules. A push into a full FIFO is still taken when a pop
   // frees the head slot on the same edge. A pop from an empty FIFO is
   // never taken, even when a push arrives alongside it; that push is
   // just a plain write. Overflow and underflow fire only for the purely
   // rejected cases.
   always_comb begin
      writeAccept    = push && (!full || pop);
      readAccept     = pop && !empty;
      overflowEvent  = push && full && !pop;
      underflowEvent = pop && empty && !push;
      op             = fifoOpDecode(readAccept, writeAccept);
   end

   // Storage. Only accepted writes reach the array, so a dropped overflow
   // push leaves the contents untouched.
   fifo_mem #(
      .DATA_SIZE    (DATA_SIZE),
      .ADDRESS_SIZE (ADDRESS_SIZE)
   ) u_mem (
      .clk      (clk),
      .wrEn_i   (writeAccept),
      .wrAddr_i (wrPtr_q),
      .wrData_i (data_in),
      .rdAddr_i (rdPtr_q),
      .rdData_o (memRdData)
   );

   // Next-state logic for pointers, count and read data. Pointers are
   // exactly ADDRESS_SIZE bits, so they wrap from DEPTH-1 to 0 for free.
   // When the FIFO is full and both requests are accepted, the read
   // pointer equals the write pointer. The head word is read out before
   // the array write lands, so the consumer still gets the old word.
   always_comb begin
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      count_d     = count_q;
      dataOut_d   = dataOut_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      case (op)
         OP_WRITE: begin
            wrPtr_d = wrPtr_q + 1'b1;
            count_d = count_q + 1'b1;
         end
         OP_READ: begin
            rdPtr_d   = rdPtr_q + 1'b1;
            count_d   = count_q - 1'b1;
            dataOut_d = memRdData;
         end
         OP_BOTH: begin
            wrPtr_d   = wrPtr_q + 1'b1;
            rdPtr_d   = rdPtr_q + 1'b1;
            dataOut_d = memRdData;
         end
         default: begin
            wrPtr_d = wrPtr_q;
         end
      endcase

      if (overflowEvent) begin
         overflow_d = 1'b1;
      end
      if (underflowEvent) begin
         underflow_d = 1'b1;
      end
   end

   // State registers. Reset is asynchronous and active low and clears
   // everything except the storage array, so reset mid-operation
   // discards the FIFO contents.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         dataOut_q   <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         dataOut_q   <= dataOut_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign data_out  = dataOut_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule : fifo

// File: tb/tb_fifo.sv
// ---------------------------------------------------------------------------
// tb_fifo
//
// Purpose:
//    Self-checking bench for the fifo block. It keeps a queue-based
//    reference model of the FIFO contents and error flags, and compares
//    every DUT output after each clock edge and during asynchronous reset.
// ---------------------------------------------------------------------------
module tb_fifo;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;
   logic          full;
   logic          empty;
   logic          overflow;
   logic          underflow;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [DW-1:0] modelQ[$];
   logic [DW-1:0] expOut = '0;
   logic          expOvf = 1'b0;
   logic          expUnf = 1'b0;

   fifo #(
      .DATA_SIZE    (DW),
      .ADDRESS_SIZE (AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .data_in   (data_in),
      .data_out  (data_out),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .underflow (underflow)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Compare all DUT outputs against the reference model.
   task automatic checkState(input string tag);
      checkOutput({tag, ".data_out"}, 32'(data_out), 32'(expOut));
      checkOutput({tag, ".full"}, 32'(full), 32'(modelQ.size() == DEPTH));
      checkOutput({tag, ".empty"}, 32'(empty), 32'(modelQ.size() == 0));
      checkOutput({tag, ".overflow"}, 32'(overflow), 32'(expOvf));
      checkOutput({tag, ".underflow"}, 32'(underflow), 32'(expUnf));
   endtask

   // Reference behaviour for one clock edge, in terms of the queue contents.
   task automatic modelStep(input logic p, input logic o, input logic [DW-1:0] d);
      bit wasFull;
      bit wasEmpty;
      wasFull  = (modelQ.size() == DEPTH);
      wasEmpty = (modelQ.size() == 0);
      if (o && !wasEmpty) expOut = modelQ.pop_front();
      if (p && (!wasFull || o)) modelQ.push_back(d);
      if (p && wasFull && !o) expOvf = 1'b1;
      if (o && wasEmpty && !p) expUnf = 1'b1;
   endtask

   task automatic modelReset();
      modelQ.delete();
      expOut = '0;
      expOvf = 1'b0;
      expUnf = 1'b0;
   endtask

   // Drive one cycle of requests (entered just after a rising edge), let
   // the edge happen, advance the model and check the outputs.
   task automatic applyStimulus(input string tag, input logic p, input logic o,
                                input logic [DW-1:0] d);
      push    = p;
      pop     = o;
      data_in = d;
      @(posedge clk);
      modelStep(p, o, d);
      #1;
      checkState(tag);
   endtask

   // Assert reset away from any clock edge. The outputs must clear at
   // once, then stay cleared across an edge before release.
   task automatic asyncReset(input string tag);
      push = 1'b0;
      pop  = 1'b0;
      rst  = 1'b0;
      #2;
      modelReset();
      checkState({tag, ".immediate"});
      @(posedge clk);
      #1;
      checkState({tag, ".held"});
      rst = 1'b1;
   endtask

   initial begin : main
      int pushPct[6] = '{50, 80, 20, 60, 95, 5};
      logic rp;
      logic ro;

      $display("[TB] starting fifo bench");

      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      modelReset();
      checkState("reset");
      rst = 1'b1;

      for (int i = 0; i < DEPTH; i++) applyStimulus("fill", 1'b1, 1'b0, DW'(i));
      applyStimulus("fullIdle", 1'b0, 1'b0, '0);
      checkOutput("fullFlag", 32'(full), 32'd1);

      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus("drain", 1'b0, 1'b1, '0);
         checkOutput("drainOrder", 32'(data_out), 32'(i));
      end
      applyStimulus("emptyIdle", 1'b0, 1'b0, '0);

      for (int i = 0; i < DEPTH; i++) applyStimulus("bothFromEmpty", 1'b1, 1'b1, DW'(i));
      checkOutput("bothLastOut", 32'(data_out), 32'd6);
      applyStimulus("bothDrain", 1'b0, 1'b1, '0);

      for (int i = 0; i < DEPTH; i++) applyStimulus("refill", 1'b1, 1'b0, DW'(8'h10 + i));
      applyStimulus("overflowPush", 1'b1, 1'b0, 8'hAA);
      checkOutput("overflowSet", 32'(overflow), 32'd1);
      applyStimulus("fullBoth", 1'b1, 1'b1, 8'h55);
      checkOutput("fullBothOut", 32'(data_out), 32'h10);
      for (int i = 0; i < DEPTH; i++) applyStimulus("postOverflowPop", 1'b0, 1'b1, '0);
      checkOutput("lastAfterOverflow", 32'(data_out), 32'h55);

      applyStimulus("underflowPop", 1'b0, 1'b1, '0);
      checkOutput("underflowSet", 32'(underflow), 32'd1);
      applyStimulus("underflowSticky", 1'b0, 1'b0, '0);
      asyncReset("midReset");
      applyStimulus("afterReset", 1'b1, 1'b0, 8'h3C);

      for (int ph = 0; ph < 6; ph++) begin
         asyncReset("phaseReset");
         for (int c = 0; c < 300; c++) begin
            rp = ($urandom_range(99) < pushPct[ph]);
            ro = ($urandom_range(99) < (100 - pushPct[ph]));
            if ($urandom_range(199) == 0) asyncReset("randReset");
            else applyStimulus("random", rp, ro, DW'($urandom));
         end
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule : tb_fifo

// File: doc/fifo.md
Name: fifo

Overview:
- Single-clock synchronous FIFO with parameterised data width and depth (2**ADDRESS_SIZE entries).
- Provides a push/pop interface with full/empty status and sticky overflow/underflow error flags.
- Used as a generic buffer between producer and consumer logic in the same clock domain.

Parameters:
- DATA_SIZE, 8, width in bits of each data word.
- ADDRESS_SIZE, 3, address width; depth DEPTH = 2**ADDRESS_SIZE (default 8 entries).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- push  input  1  write request; data_in is captured on the rising edge when accepted.
- pop  input  1  read request; the head word is presented on data_out after the rising edge when accepted.
- data_in  input  DATA_SIZE  write data.
- data_out  output  DATA_SIZE  registered read data.
- full  output  1  high when the FIFO holds DEPTH entries.
- empty  output  1  high when the FIFO holds 0 entries.
- overflow  output  1  sticky flag: a push was attempted while full without a pop.
- underflow  output  1  sticky flag: a pop was attempted while empty.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - Read/write pointers and occupancy count cleared to 0; data_out=0.
  - empty=1, full=0, overflow=0, underflow=0.
  - Storage array is not reset. Reset mid-operation discards all contents.
- Internal state:
  - DEPTH x DATA_SIZE storage array.
  - ADDRESS_SIZE-bit write and read pointers that wrap naturally from DEPTH-1 to 0.
  - Occupancy count of ADDRESS_SIZE+1 bits, range 0..DEPTH.
- full = (count == DEPTH); empty = (count == 0). Both are combinational from the registered count, so they update the same cycle count changes.
- Accepted write: push=1 and (not full, or pop=1 while full).
  - Stores data_in at the write pointer; write pointer increments.
- Accepted read: pop=1 and not empty.
  - data_out <= mem[read pointer]; read pointer increments. One-cycle latency: data is valid after the accepting edge.
  - data_out holds its last value when no read is accepted.
- Simultaneous push and pop:
  - Empty: write only; pop ignored, no underflow; count becomes 1.
  - Full: both accepted; count stays DEPTH; no overflow.
  - Otherwise: both accepted; count unchanged.
- Count update: +1 on write-only, -1 on read-only, unchanged on both or neither.
- Overflow: set on any edge with push=1, full=1, pop=0. The write is dropped and contents are unchanged. Sticky until reset.
- Underflow: set on any edge with pop=1, empty=1, push=0. Pointers and data_out are unchanged. Sticky until reset.
- No other outputs change on a rejected request.

Decomposition:
- No shared package required. The DEPTH localparam is derived inside the module.
- One natural sub-module: fifo_mem, a simple dual-port register array (write port: addr/data/en; read port: addr).
- Pointer, count and flag logic stay in fifo.

Test Plan:
- Reset: hold rst=0 for 1 cycle, release -> empty=1, full=0, overflow=0, underflow=0, data_out=0.
- Push to full: push values 0..7 on 8 consecutive edges, then deassert -> full=1, empty=0 (count 8).
- Pop to empty: 8 consecutive pops -> data_out sequence 0,1,...,7 (each one cycle after its pop edge), then empty=1, full=0, underflow=0.
- Simultaneous push+pop from empty: push=pop=1 with data 0..7 for 8 cycles -> first cycle write only; then count stays 1, data_out follows 0,1,...,6; no overflow/underflow.
- Overflow: fill with 8 pushes, then one extra push of 0xAA -> overflow=1 and stays 1; full=1; subsequent pops return the original 8 values (0xAA not stored).
- Underflow: pop all entries, then one extra pop -> underflow=1 (sticky), empty=1, data_out keeps last valid value; async reset mid-test clears both flags immediately.
